// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl (with params_pkg)
// Brief    : Fetch-stage wrapper. Owns the architectural PC, captures the
//            fetched instruction into an IF/ID holding register and hands it
//            to decode over a valid/ready handshake. Handles branch redirect
//            (flush), decode backpressure (stall) and a sticky halt.
// Revision : 1.0 - initial release
// ============================================================================

package params_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int MEM_SIZE   = 256;
  typedef logic [31:0] instruction_t;
endpackage

module pc_fetch_ctrl #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
  parameter int RESET_PC   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  output logic [ADDR_WIDTH-1:0]    pc_o,
  input  logic [ADDR_WIDTH-1:0]    next_pc_i,
  input  params_pkg::instruction_t instruction_i,
  input  logic                     branch_taken_i,
  input  logic [ADDR_WIDTH-1:0]    branch_target_i,
  input  logic                     halt_i,
  output params_pkg::instruction_t instr_o,
  output logic [ADDR_WIDTH-1:0]    instr_pc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     halted_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_PC);
  localparam logic [CNT_WIDTH-1:0]  c_cnt_max  = '1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDR_WIDTH-1:0]    r_pc;
  logic [ADDR_WIDTH-1:0]    w_pc_nxt;
  params_pkg::instruction_t r_instr;
  params_pkg::instruction_t w_instr_nxt;
  logic [ADDR_WIDTH-1:0]    r_instr_pc;
  logic [ADDR_WIDTH-1:0]    w_instr_pc_nxt;
  logic                     r_valid;
  logic                     w_valid_nxt;
  logic [CNT_WIDTH-1:0]     r_stall_cnt;
  logic                     w_accept;
  logic                     w_free;
  logic [ADDR_WIDTH-1:0]    w_target;

  assign w_accept = r_valid & ready_i;
  assign w_free   = ~r_valid | ready_i;

  // Redirect targets are folded into the instruction memory range.
  assign w_target = ADDR_WIDTH'(32'(branch_target_i) % 32'(MEM_SIZE));

  // State, PC and IF/ID register; reset discards any held entry at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_BOOT;
      r_pc       <= c_reset_pc;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  // Next-state and datapath: redirect beats capture beats stall; halt is
  // taken after the redirect/capture decision of the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    case (r_state)
      ST_BOOT: begin
        // One idle cycle lets the instruction memory settle after reset.
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken_i) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
        end else if (w_free) begin
          w_instr_nxt    = instruction_i;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = next_pc_i;
        end
        if (halt_i) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // Drain a pending entry, then stay quiet until reset.
        if (w_accept) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Saturating count of cycles where decode back-pressures a valid entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !ready_i && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pc_o        = r_pc;
  assign instr_o     = r_instr;
  assign instr_pc_o  = r_instr_pc;
  assign valid_o     = r_valid;
  assign halted_o    = (r_state == ST_HALT);
  assign stall_cnt_o = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Brief    : Self-checking bench for pc_fetch_ctrl. Expected deliveries are
//            queued in program order; a monitor pops them on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  localparam int AW = 6;
  localparam int MS = 16;
  localparam int RP = 13;
  localparam int CW = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   ins;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc_o;
  logic [AW-1:0] next_pc;
  logic [31:0]   instruction;
  logic          br = 1'b0;
  logic [AW-1:0] br_tgt = '0;
  logic          halt = 1'b0;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          valid;
  logic          ready = 1'b0;
  logic          halted;
  logic [CW-1:0] stall_cnt;

  logic [31:0]   imem [MS];
  int            n_cmp = 0;
  int            n_fail = 0;
  exp_t          exp_q[$];
  logic [AW-1:0] last_pc;

  // monitor-owned state
  int            model_stall = 0;
  bit            prev_stall = 1'b0;
  bit            prev_br = 1'b0;
  logic [AW-1:0] prev_pc;
  logic [31:0]   prev_ins;
  exp_t          mon_e;

  pc_fetch_ctrl #(
    .ADDR_WIDTH(AW),
    .MEM_SIZE  (MS),
    .RESET_PC  (RP),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pc_o           (pc_o),
    .next_pc_i      (next_pc),
    .instruction_i  (instruction),
    .branch_taken_i (br),
    .branch_target_i(br_tgt),
    .halt_i         (halt),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .valid_o        (valid),
    .ready_i        (ready),
    .halted_o       (halted),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return AW'((int'(p) + 1) % MS);
  endfunction

  function automatic logic [AW-1:0] tgt_mod(input int t);
    return AW'(t % MS);
  endfunction

  // Fetch stage model: combinational instruction and (pc+1)%MEM_SIZE.
  assign instruction = imem[pc_o[3:0]];
  assign next_pc     = nxt(pc_o);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] p);
    exp_t e;
    e.pc  = p;
    e.ins = imem[p[3:0]];
    exp_q.push_back(e);
    last_pc = p;
  endtask

  task automatic topup();
    while (exp_q.size() < 4) push_exp(nxt(last_pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic do_branch(input int t);
    br     = 1'b1;
    ready  = 1'b0;
    br_tgt = AW'(t);
    exp_q.delete();
    push_exp(tgt_mod(t));
    topup();
  endtask

  // Async reset away from any clock edge, then release and wait out BOOT.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_pc", pc_o, RP);
    check("rst_stall", stall_cnt, 0);
    check("rst_halted", halted, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_instr", instr, 0);
    exp_q.delete();
    push_exp(AW'(RP));
    topup();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    @(negedge clk);
    check("boot_valid", valid, 0);
  endtask

  task automatic halt_test(input bit stalled);
    logic [AW-1:0] pre_pc;
    logic [AW-1:0] frozen;
    tick();
    ready = stalled ? 1'b0 : 1'b1;
    tick();
    halt   = 1'b1;
    pre_pc = stalled ? instr_pc : pc_o;
    tick();
    halt = 1'b0;
    @(negedge clk);
    check("halted", halted, 1);
    check("halt_valid", valid, 1);
    check("halt_entry_pc", instr_pc, pre_pc);
    frozen = pc_o;
    check("halt_pc", frozen, nxt(pre_pc));
    if (stalled) begin
      repeat (2) begin
        tick();
        @(negedge clk);
        check("halt_hold_pc", instr_pc, pre_pc);
        check("halt_frozen", pc_o, frozen);
      end
      tick();
      ready = 1'b1;
      @(negedge clk);
    end
    repeat (4) begin
      tick();
      @(negedge clk);
      check("halt_drained", valid, 0);
      check("halt_frozen", pc_o, frozen);
      check("halt_sticky", halted, 1);
    end
  endtask

  // Scoreboard monitor: compares every handshake against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_stall = 0;
      prev_stall  = 1'b0;
      prev_br     = 1'b0;
    end else begin
      check("stall_cnt", stall_cnt, model_stall);
      if (valid) check("pc_ahead", pc_o, nxt(instr_pc));
      if (prev_stall && !prev_br) begin
        check("hold_valid", valid, 1);
        check("hold_pc", instr_pc, prev_pc);
        check("hold_ins", instr, prev_ins);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_accept: got pc 0x%0h expected none", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("deliver_pc", instr_pc, mon_e.pc);
          check("deliver_ins", instr, mon_e.ins);
        end
      end
      prev_stall = valid && !ready;
      prev_br    = br;
      prev_pc    = instr_pc;
      prev_ins   = instr;
      if (valid && !ready && model_stall < (1 << CW) - 1) model_stall++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MS; i++) imem[i] = $urandom;
    exp_q.delete();
    push_exp(AW'(RP));
    topup();
    #12;
    check("por_valid", valid, 0);
    check("por_pc", pc_o, RP);
    check("por_stall", stall_cnt, 0);
    check("por_halted", halted, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;

    // BOOT cycle then back-to-back delivery across the PC wrap.
    for (int k = 1; k <= 6; k++) begin
      tick();
      @(negedge clk);
      if (k == 1) begin
        check("boot_valid", valid, 0);
      end else begin
        check("stream_valid", valid, 1);
        check("stream_pc", instr_pc, (RP + k - 2) % MS);
      end
    end

    // Three stall cycles.
    tick();
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_entry", instr_pc, (RP + 5) % MS);
      check("stall_pc", pc_o, (RP + 6) % MS);
      tick();
    end
    ready = 1'b1;
    @(negedge clk);
    check("stall_cnt3", stall_cnt, 3);
    tick();
    @(negedge clk);
    check("after_stall", instr_pc, (RP + 6) % MS);

    // Redirect while stalled.
    tick();
    ready = 1'b0;
    tick();
    do_branch(40);
    tick();
    br    = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("flush_valid", valid, 0);
    check("flush_pc", pc_o, tgt_mod(40));
    tick();
    @(negedge clk);
    check("target_valid", valid, 1);
    check("target_pc", instr_pc, tgt_mod(40));

    // Random traffic with occasional redirects.
    repeat (300) begin
      tick();
      br = 1'b0;
      if ($urandom_range(0, 15) == 0) do_branch(int'($urandom_range(0, 63)));
      else ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    br    = 1'b0;
    ready = 1'b0;
    tick();
    @(negedge clk);
    check("pre_reset_valid", valid, 1);
    check("stall_saturated", stall_cnt, (1 << CW) - 1);

    do_reset();
    repeat (5) tick();
    halt_test(1'b0);

    @(negedge clk);
    do_reset();
    repeat (3) tick();
    halt_test(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Upstream/downstream wrapper for the fetch stage in the multi-cycle core.
- Owns the architectural PC register and drives pc_o into the fetch stage; consumes that stage's next_pc and instruction.
- Captures fetched instructions into an IF/ID holding register and presents them to decode with a valid/ready handshake.
- Handles branch redirect (flush), backpressure stall and halt.

Parameters:
- ADDR_WIDTH, params_pkg::ADDR_WIDTH, PC/address width.
- MEM_SIZE, params_pkg::MEM_SIZE, instruction memory depth in words; PC range is 0..MEM_SIZE-1.
- RESET_PC, 0, PC value loaded on reset; must be < MEM_SIZE.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk_i  input  1  single clock, all state on rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- pc_o  output  ADDR_WIDTH  current PC, to fetch stage pc_i.
- next_pc_i  input  ADDR_WIDTH  (pc+1)%MEM_SIZE from fetch stage.
- instruction_i  input  instruction_t  combinational fetch result for pc_o.
- branch_taken_i  input  1  redirect request from execute, one-cycle pulse.
- branch_target_i  input  ADDR_WIDTH  redirect target.
- halt_i  input  1  stop fetching; sticky until reset.
- instr_o  output  instruction_t  IF/ID instruction to decode.
- instr_pc_o  output  ADDR_WIDTH  PC of instr_o.
- valid_o  output  1  instr_o/instr_pc_o valid.
- ready_i  input  1  decode accepts this cycle.
- halted_o  output  1  controller in HALT.
- stall_cnt_o  output  CNT_WIDTH  cycles with valid_o=1 and ready_i=0, saturating.

Behaviour:
- Reset (async, rst_n_i=0):
  - pc_o=RESET_PC; instr_o=0; instr_pc_o=0; valid_o=0.
  - halted_o=0; stall_cnt_o=0; state=BOOT.
  - Reset mid-operation discards the IF/ID contents immediately.
- State machine:
  - BOOT: one cycle, no capture, valid_o stays 0; -> RUN. Covers imem settle after reset deassert.
  - RUN: normal operation; -> HALT when halt_i=1 (evaluated after the redirect/capture rules for that cycle).
  - HALT: pc_o frozen, no new captures. An already-valid IF/ID entry is still held until ready_i accepts it, then valid_o=0. halted_o=1. Stays until reset.
- Accept condition: accept = valid_o & ready_i.
- Slot free condition: free = ~valid_o | ready_i.
- RUN cycle priority:
  1. branch_taken_i=1: pc <= branch_target_i % MEM_SIZE; valid_o <= 0 (flush, squash any held or incoming instruction); capture suppressed. Redirect wins over stall and halt in the same cycle.
  2. else free=1: instr_o <= instruction_i; instr_pc_o <= pc_o; valid_o <= 1; pc <= next_pc_i.
  3. else (stall): pc, instr_o, instr_pc_o, valid_o all held.
- Timing:
  - Fetch-to-valid latency is 1 cycle: the instruction at pc_o this cycle appears on instr_o the next cycle.
  - Throughput is 1 instruction/cycle with ready_i held at 1.
- PC wrap: when pc=MEM_SIZE-1, next_pc_i=0; the controller uses next_pc_i unmodified, no internal increment.
- halt_i with a stalled entry: the entry is kept; no further fetch.
- halt_i and free in the same cycle: the capture still occurs, then HALT.
- stall_cnt_o:
  - Increments when valid_o=1 & ready_i=0, in any state.
  - Saturates at 2^CNT_WIDTH-1.
  - Cleared only by reset.
- Handshake stability: while valid_o=1 & ready_i=0, instr_o/instr_pc_o must not change, except on flush (valid_o drops).

Test Plan:
- Reset release with ready_i=1 and imem preloaded 0..7 -> cycle 1 valid_o=0 (BOOT); cycles 2..9 instr_pc_o=0,1,...,7 back-to-back with the matching instr_o.
- ready_i=0 for 3 cycles while instr_pc_o=4 -> instr_o/instr_pc_o held at 4, pc_o held at 5, stall_cnt_o=3; ready_i=1 -> next instr_pc_o=5.
- Redirect: branch_taken_i=1, target=20 while stalled at instr_pc_o=6 -> next cycle valid_o=0, pc_o=20; following cycle instr_pc_o=20, valid_o=1.
- Wrap: MEM_SIZE=16, run from pc 14 -> instr_pc_o sequence 14,15,0,1.
- Halt: halt_i=1 with ready_i=0 holding pc 9 -> halted_o=1, entry held; ready_i=1 -> valid_o=0 next cycle, pc_o frozen at 10 thereafter.
- Async reset asserted mid-stream with valid_o=1 -> valid_o=0, pc_o=RESET_PC, stall_cnt_o=0 without waiting for a clock edge.
